// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester ids.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_MEM = 1'b0;
    localparam port_id_t PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle: valid/ready request beat plus tagged read return.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, we, lock, addr, wdata, input ready, rvalid, rdata);
    modport slave  (input valid, we, lock, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is granted.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | (last == PORT_DBG));
    assign grant[1] = req[1] & (~req[0] | (last == PORT_MEM));

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the MEM stage and loader port.
// Optional statistics counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     rq0,
    dmem_arbiter_if.slave     rq1,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [7:0]        preempt_cnt
`endif
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_OWN0   = OWN0;
    localparam logic [1:0] ST_OWN1   = OWN1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0]        state;
    port_id_t          rr_last;
    logic [7:0]        hold_cnt;
    logic              rd_pend;
    port_id_t          rd_tag;

    logic [1:0]        req;
    logic [1:0]        pick;
    logic [1:0]        grant;
    logic              accept;
    port_id_t          gnt_port;
    port_id_t          own_port;
    logic              in_own;
    logic              other_waiting;
    logic              preempt;
    logic              conflict;
    logic              b_we;
    logic              b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;

    assign req = {rq1.valid, rq0.valid};

    rr_pick2 u_pick (
        .req   (req),
        .last  (rr_last),
        .grant (pick)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 2'b00;
        if (reset) begin
            case (state)
                ST_IDLE: grant = pick;
                ST_OWN0: grant = {1'b0, req[0]};
                ST_OWN1: grant = {req[1], 1'b0};
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept   = |grant;
    assign gnt_port = port_id_t'(grant[1]);

    always_comb begin
        b_we    = rq0.we;
        b_lock  = rq0.lock;
        b_addr  = rq0.addr;
        b_wdata = rq0.wdata;
        if (gnt_port == PORT_DBG) begin
            b_we    = rq1.we;
            b_lock  = rq1.lock;
            b_addr  = rq1.addr;
            b_wdata = rq1.wdata;
        end
    end

    assign mem_we    = accept & b_we;
    assign mem_re    = accept & ~b_we;
    assign mem_addr  = accept ? b_addr  : '0;
    assign mem_wdata = accept ? b_wdata : '0;

    assign rq0.ready = grant[0];
    assign rq1.ready = grant[1];

    // Outputs are forced to zero while reset is held, including a read return in flight.
    assign busy       = reset & (state != ST_IDLE);
    assign rq0.rvalid = reset & rd_pend & (rd_tag == PORT_MEM);
    assign rq1.rvalid = reset & rd_pend & (rd_tag == PORT_DBG);
    assign rq0.rdata  = rq0.rvalid ? mem_rdata : '0;
    assign rq1.rdata  = rq1.rvalid ? mem_rdata : '0;

    assign in_own        = (state == ST_OWN0) | (state == ST_OWN1);
    assign own_port      = port_id_t'(state == ST_OWN1);
    assign other_waiting = (own_port == PORT_DBG) ? req[0] : req[1];
    assign preempt       = in_own & other_waiting & (hold_cnt == HOLD_LAST);
    assign conflict      = (state == ST_IDLE) & (&req);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rr_last  <= PORT_DBG;
            hold_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_tag   <= PORT_MEM;
        end else begin
            rd_pend <= mem_re;
            rd_tag  <= gnt_port;
            if (conflict) rr_last <= gnt_port;

            if (preempt) begin
                // The waiting port takes the next tie; this cycle's beat still completes.
                state    <= ST_IDLE;
                hold_cnt <= '0;
                rr_last  <= own_port;
            end else if (in_own) begin
                if (accept && !b_lock) begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end else if (other_waiting) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end else if (accept && b_lock) begin
                state <= (gnt_port == PORT_DBG) ? ST_OWN1 : ST_OWN0;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt <= '0;
            preempt_cnt  <= '0;
        end else begin
            if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
            if (preempt && preempt_cnt != 8'hFF)      preempt_cnt  <= preempt_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int MAXH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rq0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rq1 ();

    logic          mem_we, mem_re, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt;
    logic [7:0]    preempt_cnt;
`endif

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAXH)) dut (
        .clk          (clk),
        .reset        (reset),
        .rq0          (rq0.slave),
        .rq1          (rq1.slave),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .preempt_cnt  (preempt_cnt)
`endif
    );

    // Environment memory: 256x8, registered read data one cycle after mem_re.
    logic [7:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= env_mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner -1 means nobody holds the memory.
    logic [7:0] m_mem [256];
    int         m_owner, m_last, m_hold, m_pend_port, m_conf, m_pre;
    bit         m_pend;
    logic [7:0] m_pend_data;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_hold = 0;
        m_pend = 0; m_pend_port = 0; m_pend_data = '0;
        m_conf = 0; m_pre = 0;
    endtask

    task automatic model_check();
        bit v[2], w[2], l[2];
        logic [7:0] a[2], d[2];
        bit e_rv[2];
        logic [7:0] e_rd[2];
        bit e_we, e_re, e_busy;
        logic [7:0] e_addr, e_wd;
        int win, other;
        v[0] = rq0.valid; w[0] = rq0.we; l[0] = rq0.lock; a[0] = rq0.addr; d[0] = rq0.wdata;
        v[1] = rq1.valid; w[1] = rq1.we; l[1] = rq1.lock; a[1] = rq1.addr; d[1] = rq1.wdata;
        e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
        e_we = 0; e_re = 0; e_addr = '0; e_wd = '0; e_busy = 0;
        win = -1;
        if (reset) begin
            if (m_pend) begin
                e_rv[m_pend_port] = 1;
                e_rd[m_pend_port] = m_pend_data;
            end
            if (m_owner < 0) begin
                if (v[0] && v[1]) win = (m_last == 0) ? 1 : 0;
                else if (v[0])    win = 0;
                else if (v[1])    win = 1;
            end else if (v[m_owner]) begin
                win = m_owner;
            end
            e_busy = (m_owner >= 0);
            if (win >= 0) begin
                e_we = w[win]; e_re = !w[win]; e_addr = a[win]; e_wd = d[win];
            end
        end

        chk("ready0",  32'(rq0.ready),  32'(win == 0));
        chk("ready1",  32'(rq1.ready),  32'(win == 1));
        chk("rvalid0", 32'(rq0.rvalid), 32'(e_rv[0]));
        chk("rvalid1", 32'(rq1.rvalid), 32'(e_rv[1]));
        chk("rdata0",  32'(rq0.rdata),  32'(e_rd[0]));
        chk("rdata1",  32'(rq1.rdata),  32'(e_rd[1]));
        chk("mem_we",  32'(mem_we),     32'(e_we));
        chk("mem_re",  32'(mem_re),     32'(e_re));
        chk("mem_addr", 32'(mem_addr),  32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("busy",    32'(busy),       32'(e_busy));
`ifdef DMEM_ARB_STATS_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        chk("preempt_cnt",  32'(preempt_cnt),  32'(m_pre));
`endif

        if (!reset) begin
            model_reset();
        end else begin
            if (m_owner < 0 && v[0] && v[1]) begin
                m_last = win;
                if (m_conf < 65535) m_conf++;
            end
            m_pend = (win >= 0) && !w[win];
            if (m_pend) begin
                m_pend_port = win;
                m_pend_data = m_mem[a[win]];
            end
            if (win >= 0 && w[win]) m_mem[a[win]] = d[win];
            if (m_owner < 0) begin
                if (win >= 0 && l[win]) m_owner = win;
            end else begin
                other = 1 - m_owner;
                if (v[other] && m_hold + 1 == MAXH) begin
                    m_last = m_owner; m_owner = -1; m_hold = 0;
                    if (m_pre < 255) m_pre++;
                end else if (win == m_owner && !l[win]) begin
                    m_owner = -1; m_hold = 0;
                end else if (v[other]) begin
                    m_hold++;
                end
            end
        end
    endtask

    task automatic drive(input int p, input bit val, input bit we, input bit lock,
                         input logic [7:0] addr, input logic [7:0] wd);
        if (p == 0) begin
            rq0.valid = val; rq0.we = we; rq0.lock = lock; rq0.addr = addr; rq0.wdata = wd;
        end else begin
            rq1.valid = val; rq1.we = we; rq1.lock = lock; rq1.addr = addr; rq1.wdata = wd;
        end
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1 ns later, well before the next rising edge.
    task automatic cyc();
        #1;
        model_check();
    endtask

    bit         hv[2], acc[2], rwe[2], rlk[2];
    logic [7:0] rad[2], rwd[2];

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'(i * 34);
            m_mem[i]   = 8'(i * 34);
        end
        model_reset();
        drive(0, 1, 0, 0, 8'h02, 8'h00);
        drive(1, 1, 1, 0, 8'h03, 8'h55);
        @(negedge clk);

        // Requests held during reset must not be granted.
        cyc(); chk("rst_ready0", 32'(rq0.ready), 0); chk("rst_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        cyc(); chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1;
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);

        // Single port-0 read.
        drive(0, 1, 0, 0, 8'h02, 8'h00);
        cyc(); chk("t1_ready0", 32'(rq0.ready), 1); chk("t1_mem_re", 32'(mem_re), 1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h02);
        @(negedge clk);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        cyc(); chk("t1_rvalid0", 32'(rq0.rvalid), 1); chk("t1_rdata0", 32'(rq0.rdata), 32'h44);
        chk("t1_rvalid1", 32'(rq1.rvalid), 0);
        @(negedge clk);

        // First tie after reset goes to port 0.
        drive(0, 1, 0, 0, 8'h00, 8'h00);
        drive(1, 1, 0, 0, 8'h01, 8'h00);
        cyc(); chk("t2_ready0", 32'(rq0.ready), 1); chk("t2_ready1", 32'(rq1.ready), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        cyc(); chk("t2_ready1_next", 32'(rq1.ready), 1);
        @(negedge clk);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        cyc(); chk("t2_rvalid1", 32'(rq1.rvalid), 1); chk("t2_rdata1", 32'(rq1.rdata), 32'h22);
        @(negedge clk);

        // Locked read-modify-write on port 1 stalls port 0 for two beats.
        drive(1, 1, 0, 1, 8'h05, 8'h00);
        drive(0, 1, 0, 0, 8'h03, 8'h00);
        cyc(); chk("t3_ready1_a", 32'(rq1.ready), 1); chk("t3_ready0_a", 32'(rq0.ready), 0);
        @(negedge clk);
        drive(1, 1, 1, 0, 8'h05, 8'hAB);
        cyc(); chk("t3_ready1_b", 32'(rq1.ready), 1); chk("t3_ready0_b", 32'(rq0.ready), 0);
        chk("t3_rdata1", 32'(rq1.rdata), 32'hAA);
        @(negedge clk);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        cyc(); chk("t3_ready0_c", 32'(rq0.ready), 1);
        @(negedge clk);
        drive(0, 1, 0, 0, 8'h05, 8'h00);
        cyc(); chk("t3_rdata0_old", 32'(rq0.rdata), 32'h66);
        @(negedge clk);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        cyc(); chk("t3_rdata0_new", 32'(rq0.rdata), 32'hAB);
        @(negedge clk);

        // Port 0 sits on a lock while port 1 waits: preempted after MAX_HOLD cycles.
        drive(0, 1, 0, 1, 8'h10, 8'h00);
        drive(1, 1, 0, 0, 8'h20, 8'h00);
        cyc(); chk("t4_ready0", 32'(rq0.ready), 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < MAXH; i++) begin
            cyc(); chk("t4_hold_ready1", 32'(rq1.ready), 0); chk("t4_hold_busy", 32'(busy), 1);
            @(negedge clk);
        end
        cyc(); chk("t4_ready1", 32'(rq1.ready), 1); chk("t4_busy", 32'(busy), 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        cyc();
`ifdef DMEM_ARB_STATS_EN
        chk("t4_preempt_cnt", 32'(preempt_cnt), 1);
`endif
        @(negedge clk);

        // Reset right after a read is accepted drops the return.
        drive(0, 1, 0, 0, 8'h02, 8'h00);
        cyc(); chk("t5_ready0", 32'(rq0.ready), 1);
        @(negedge clk);
        reset = 0;
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        cyc(); chk("t5_rvalid0", 32'(rq0.rvalid), 0); chk("t5_rdata0", 32'(rq0.rdata), 0);
        @(negedge clk);
        reset = 1;
        cyc(); chk("t5_rvalid0_after", 32'(rq0.rvalid), 0); chk("t5_busy", 32'(busy), 0);
        @(negedge clk);

        // Sustained ties alternate grants.
        drive(0, 1, 0, 0, 8'h07, 8'h00);
        drive(1, 1, 0, 0, 8'h08, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(); chk("t6_grant0", 32'(rq0.ready), 32'(i % 2 == 0));
            chk("t6_grant1", 32'(rq1.ready), 32'(i % 2 == 1));
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        cyc();
`ifdef DMEM_ARB_STATS_EN
        chk("t6_conflict_cnt", 32'(conflict_cnt), 10);
`endif
        @(negedge clk);

        // Randomized traffic; each requester holds its beat stable until accepted.
        hv[0] = 0; hv[1] = 0; acc[0] = 0; acc[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (hv[p] && acc[p]) hv[p] = 0;
                if (!hv[p] && $urandom_range(0, 2) != 0) begin
                    hv[p]  = 1;
                    rwe[p] = 1'($urandom_range(0, 1));
                    rlk[p] = ($urandom_range(0, 1) == 0);
                    rad[p] = 8'($urandom_range(0, 15));
                    rwd[p] = 8'($urandom);
                end
                drive(p, hv[p], rwe[p], rlk[p], rad[p], rwd[p]);
            end
            reset = ($urandom_range(0, 299) != 0);
            cyc();
            acc[0] = rq0.ready;
            acc[1] = rq1.ready;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
